// File: rtl/ov7670_sccb_master.sv
// SCCB 3-phase write master for the OV7670: device ID, register address, value.
// Define OV7670_SCCB_NACK_DETECT_EN to sample the ACK bits and report nack.
module ov7670_sccb_master #(
    parameter int         CLK_DIV   = 250,
    parameter logic [7:0] DEVICE_ID = 8'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] data,
    output logic        ready,
    output logic        done,
    output logic        nack,
    output logic        sioc,
    output logic        siod_out,
    output logic        siod_oe,
    input  logic        siod_in
);
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BYTE, S_STOP, S_BUSFREE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [4:0]    bit_q, bit_d;
    logic [15:0]   data_q, data_d;
    logic          err_q, err_d;
    logic          nack_q, nack_d;
    logic          sioc_q, sioc_d;
    logic          siod_q, siod_d;
    logic          oe_q, oe_d;
    logic          tick;
    logic [4:0]    cur_bip;
    logic [4:0]    nxt_bip;
    logic [4:0]    nxt_phase;
    logic [7:0]    nxt_byte;

    assign tick    = (div_q == DW'(CLK_DIV - 1));
    assign cur_bip = bit_q % 5'd9;

`ifndef OV7670_SCCB_NACK_DETECT_EN
    logic unused_siod;
    assign unused_siod = siod_in;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        data_d  = data_q;
        err_d   = err_q;
        nack_d  = nack_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_START;
                    div_d   = '0;
                    qtr_d   = '0;
                    bit_d   = '0;
                    data_d  = data;
                    err_d   = 1'b0;
                    nack_d  = 1'b0;
                end
            end
            default: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
`ifdef OV7670_SCCB_NACK_DETECT_EN
                    if (state_q == S_BYTE && qtr_q == 2'd2 &&
                        cur_bip == 5'd8 && siod_in)
                        err_d = 1'b1;
`endif
                    if (qtr_q == 2'd3) begin
                        unique case (state_q)
                            S_START: state_d = S_BYTE;
                            S_BYTE: begin
                                if (bit_q == 5'd26) state_d = S_STOP;
                                else bit_d = bit_q + 5'd1;
                            end
                            S_STOP: state_d = S_BUSFREE;
                            default: begin
                                state_d = S_DONE;
                                nack_d  = err_q;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    // Pin levels are derived from the next state so they change with it.
    always_comb begin
        nxt_bip   = bit_d % 5'd9;
        nxt_phase = bit_d / 5'd9;
        case (nxt_phase)
            5'd0:    nxt_byte = DEVICE_ID;
            5'd1:    nxt_byte = data_d[15:8];
            default: nxt_byte = data_d[7:0];
        endcase
        sioc_d = 1'b1;
        siod_d = 1'b1;
        oe_d   = 1'b1;
        case (state_d)
            S_START: begin
                sioc_d = ~qtr_d[1];
                siod_d = (qtr_d == 2'd0);
            end
            S_BYTE: begin
                sioc_d = qtr_d[0] ^ qtr_d[1];
                if (nxt_bip == 5'd8) oe_d = 1'b0;
                else siod_d = nxt_byte[3'(5'd7 - nxt_bip)];
            end
            S_STOP: begin
                sioc_d = (qtr_d != 2'd0);
                siod_d = qtr_d[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            nack_q  <= 1'b0;
            sioc_q  <= 1'b1;
            siod_q  <= 1'b1;
            oe_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            err_q   <= err_d;
            nack_q  <= nack_d;
            sioc_q  <= sioc_d;
            siod_q  <= siod_d;
            oe_q    <= oe_d;
        end
    end

    assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign done     = (state_q == S_DONE);
    assign nack     = nack_q;
    assign sioc     = sioc_q;
    assign siod_out = siod_q;
    assign siod_oe  = oe_q;

endmodule

// File: tb/tb_ov7670_sccb_master.sv
// Randomised bench for ov7670_sccb_master with a quarter-level waveform model.
// Expectations adapt to whether OV7670_SCCB_NACK_DETECT_EN is defined.
module tb_ov7670_sccb_master;
    localparam int D = 4;
    localparam int T = 120 * D;
`ifdef OV7670_SCCB_NACK_DETECT_EN
    localparam bit NACK_EN = 1'b1;
`else
    localparam bit NACK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data = '0;
    logic        ready, done, nack, sioc, siod_out, siod_oe;
    logic        siod_in = 1'b1;

    ov7670_sccb_master #(.CLK_DIV(D), .DEVICE_ID(8'h42)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data),
        .ready(ready), .done(done), .nack(nack), .sioc(sioc),
        .siod_out(siod_out), .siod_oe(siod_oe), .siod_in(siod_in)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: cycles since acceptance, latched word and ACK-drive mask.
    logic        m_active = 1'b0;
    int          m_k = 0;
    logic [15:0] m_word = '0;
    logic [2:0]  m_mask = '0;
    logic        m_nack = 1'b0;
    logic [2:0]  cur_mask = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_nack   <= 1'b0;
        end else if (start && (!m_active || m_k == T)) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_word   <= data;
            m_mask   <= cur_mask;
            m_nack   <= 1'b0;
        end else if (m_active) begin
            if (m_k == T) m_active <= 1'b0;
            else m_k <= m_k + 1;
            if (m_k == T - 1) m_nack <= NACK_EN && (|m_mask);
        end
    end

    // {sioc, siod, oe} for quarter index qi of a transaction
    function automatic logic [2:0] lv(input int qi, input logic [15:0] w);
        logic [2:0] st [4];
        logic [2:0] sp [4];
        logic [7:0] by;
        int b, qq, p, bi;
        logic c;
        st = '{3'b111, 3'b101, 3'b001, 3'b001};
        sp = '{3'b001, 3'b101, 3'b111, 3'b111};
        if (qi < 4) return st[qi];
        if (qi < 112) begin
            b  = (qi - 4) / 4;
            qq = (qi - 4) % 4;
            p  = b / 9;
            bi = b % 9;
            by = (p == 0) ? 8'h42 : (p == 1) ? w[15:8] : w[7:0];
            c  = (qq == 1 || qq == 2);
            if (bi == 8) return {c, 1'b1, 1'b0};
            return {c, by[7-bi], 1'b1};
        end
        if (qi < 116) return sp[qi-112];
        return 3'b111;
    endfunction

    logic prev_c = 1'b1, prev_d = 1'b1, prev_oe = 1'b1;
    int   nrise = 0, oe_low = 0, fall_hi = 0, rise_hi = 0;
    logic bits [27];
    logic oeb  [27];

    always @(negedge clk) begin
        logic [2:0] e;
        logic er, ed;
        int qi, b;
        if (!m_active) begin
            e = 3'b111; er = 1'b1; ed = 1'b0;
        end else if (m_k == T) begin
            e = 3'b111; er = 1'b1; ed = 1'b1;
        end else begin
            e = lv(m_k / D, m_word); er = 1'b0; ed = 1'b0;
        end
        chk("sioc", sioc, e[2]);
        chk("siod_oe", siod_oe, e[0]);
        if (e[0]) chk("siod_out", siod_out, e[1]);
        chk("ready", ready, er);
        chk("done", done, ed);
        chk("nack", nack, m_nack);

        if (m_active && m_k == 0) begin
            nrise = 0; oe_low = 0; fall_hi = 0; rise_hi = 0;
        end
        if (prev_c && sioc && prev_oe && siod_oe && prev_d != siod_out) begin
            if (siod_out) rise_hi++;
            else fall_hi++;
        end
        if (!prev_c && sioc) begin
            if (nrise < 27) begin
                bits[nrise] = siod_out;
                oeb[nrise]  = siod_oe;
            end
            nrise++;
        end
        if (m_active && !siod_oe) oe_low++;
        prev_c = sioc; prev_d = siod_out; prev_oe = siod_oe;

        qi = m_k / D;
        b  = (qi - 4) / 4;
        if (m_active && m_k < T && qi >= 4 && qi < 112 && (b % 9) == 8)
            siod_in = m_mask[b/9];
        else
            siod_in = 1'($urandom_range(1));
    end

    task automatic wait_done(input bit glitch, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < T + 20) begin
            if (glitch) begin
                if (lat < T - 10 && $urandom_range(15) == 0) begin
                    start = 1'b1;
                    data  = 16'($urandom);
                end else start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        if (glitch) start = 1'b0;
        chk("done_seen", done, 1'b1);
    endtask

    task automatic check_txn(input logic [15:0] w);
        logic [7:0] b0, b1, b2;
        int ne;
        #1;
        for (int i = 0; i < 8; i++) begin
            b0[7-i] = bits[i];
            b1[7-i] = bits[9+i];
            b2[7-i] = bits[18+i];
        end
        ne = 0;
        for (int i = 0; i < 27; i++) ne += int'(oeb[i]);
        chk("byte_id", b0, 8'h42);
        chk("byte_addr", b1, w[15:8]);
        chk("byte_val", b2, w[7:0]);
        chk("sioc_rises", nrise, 28);
        chk("ack_release", {oeb[8], oeb[17], oeb[26]}, 3'b000);
        chk("oe_high_bits", ne, 24);
        chk("oe_low_cycles", oe_low, 48);
        chk("start_cond", fall_hi, 1);
        chk("stop_cond", rise_hi, 1);
    endtask

    task automatic do_write(input logic [15:0] w, input logic [2:0] m,
                            input bit glitch);
        int lat;
        start = 1'b1; data = w; cur_mask = m;
        @(negedge clk);
        start = 1'b0;
        chk("nack_at_accept", nack, 1'b0);
        wait_done(glitch, lat);
        chk("latency", lat, T);
        check_txn(w);
    endtask

    initial begin
        int lat;
        time t1;
        logic [15:0] w;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_nack", nack, 1'b0);
        chk("rst_lines", {sioc, siod_out, siod_oe}, 3'b111);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        do_write(16'h1280, 3'b000, 1'b0);
        repeat (5) @(negedge clk);

        // busy start ignored, then back-to-back via held start
        start = 1'b1; data = 16'ha5c3; cur_mask = 3'b000;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1; data = 16'h1100;
        @(negedge clk);
        start = 1'b0;
        repeat (T - 110) @(negedge clk);
        start = 1'b1; data = 16'h3a04;
        wait_done(1'b0, lat);
        t1 = $time;
        check_txn(16'ha5c3);
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, lat);
        chk("b2b_gap", int'(($time - t1) / 10), T + 1);
        check_txn(16'h3a04);
        repeat (3) @(negedge clk);

        // reset during the register-address phase
        start = 1'b1; data = 16'($urandom); cur_mask = 3'b000;
        @(negedge clk);
        start = 1'b0;
        repeat (50 * D) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_lines", {sioc, siod_out, siod_oe}, 3'b111);
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_done", done, 1'b0);
        repeat (20) @(negedge clk);
        do_write(16'h4010, 3'b000, 1'b0);
        repeat (4) @(negedge clk);

        do_write(16'h0c04, 3'b010, 1'b0);
        chk("nack_phase2", nack, NACK_EN);
        repeat (4) @(negedge clk);
        chk("nack_hold", nack, NACK_EN);
        do_write(16'h3e00, 3'b000, 1'b0);
        chk("nack_clear", nack, 1'b0);

        // sequencer loop: done starts the next of 55 writes
        for (int i = 0; i < 55; i++) begin
            w = (i == 54) ? 16'h13e5 : 16'($urandom);
            do_write(w, 3'($urandom_range(7)), 1'b1);
        end
        chk("seq_last_val", {bits[18], bits[19], bits[20], bits[21],
                             bits[22], bits[23], bits[24], bits[25]}, 8'he5);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ov7670_sccb_master.md
# ov7670_sccb_master

Serial Camera Control Bus (SCCB) write master for the OV7670 camera. It takes one 16-bit `{REG_ADDR, REG_VALUE}` word from the register-initialisation sequencer and runs a 3-phase SCCB write on SIO_C/SIO_D: device ID, then register address, then value. When the bus cycle finishes it pulses `done`, and that pulse drives the sequencer's `continue` input. It sits between the init sequencer and the camera's SCCB pins.

## Interface
- `CLK_DIV`, default 250: number of `clk` cycles per SCCB quarter-bit. Minimum 2. 100 MHz / (4×250) gives 100 kHz SIO_C.
- `DEVICE_ID`, default 8'h42: 8-bit SCCB write ID, sent as phase 1.
- `clk`  in  1: core clock; single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a write of `data`; accepted only while `ready`=1.
- `data`  in  16: `{REG_ADDR[15:8], REG_VALUE[7:0]}`; latched on acceptance.
- `ready`  out  1: high in IDLE.
- `done`  out  1: one-cycle pulse at the end of a transaction.
- `nack`  out  1: acknowledge error flag (see Configuration).
- `sioc`  out  1: SIO_C, always driven.
- `siod_out`  out  1: SIO_D output value.
- `siod_oe`  out  1: SIO_D output enable; 0 = released (tristate).
- `siod_in`  in  1: SIO_D pad input.

## Operation
- Reset values: `ready`=1, `done`=0, `nack`=0, `sioc`=1, `siod_out`=1, `siod_oe`=1. The quarter counter and bit counter clear.
- Reset mid-transaction aborts immediately to IDLE with the reset values above. No stop condition is generated.
- Acceptance: `start`=1 and `ready`=1 on a rising edge.
  - Latches `data`, clears `nack`, clears the quarter divider, enters START.
  - `start` while busy is ignored and not queued.
- Quarter tick: asserted every `CLK_DIV` cycles. The state machine advances only on ticks, four quarters (q0–q3) per step.
- States:
  - **IDLE**: bus lines at idle.
  - **START** (4 quarters):
    - q0: SIOC=1, SIOD=1.
    - q1: SIOD=0.
    - q2: SIOC=0.
    - q3: hold.
  - **BYTE**: 3 phases × 9 bits, MSB first. Phase order is `DEVICE_ID`, `REG_ADDR`, `REG_VALUE`. Each bit:
    - q0: SIOC=0, set SIOD.
    - q1: SIOC=1.
    - q2: SIOC=1, sample point.
    - q3: SIOC=0.
    - Bit 9 of each phase is the don't-care/ACK bit: `siod_oe`=0 for all four quarters.
  - **STOP** (4 quarters):
    - q0: SIOC=0, SIOD=0, `siod_oe`=1.
    - q1: SIOC=1.
    - q2: SIOD=1.
    - q3: hold.
  - **BUSFREE** (4 quarters): idle levels; guarantees bus-free time before the next START.
  - **DONE** (1 clk): `done`=1, then IDLE.
- The bit counter runs 0..26. Phase = counter / 9, bit-in-phase = counter mod 9.
- `sioc`, `siod_out` and `siod_oe` are registered outputs.

## Timing
- A transaction is 4 + 108 + 4 + 4 = 120 quarter ticks.
- `done` is high exactly 120×`CLK_DIV` cycles after the accepting edge.
- `ready` rises in the same cycle that `done` is high.
- A new `start` can be accepted in the `done` cycle, giving back-to-back transactions with no extra gap.
- SIOD changes only while SIOC is low, except during START and STOP.
- SIOD is stable from q0 through q3 of every bit.
- `nack` updates in the `done` cycle and holds until the next acceptance or reset.

## Configuration
- `OV7670_SCCB_NACK_DETECT_EN` defined:
  - `siod_in` is sampled at q2 of bit 9 in each phase.
  - Any phase sampled as 1 sets an internal sticky error.
  - The sticky error is copied to `nack` at `done`. The transaction still completes.
- Not defined: `siod_in` is ignored and `nack` is tied to 0.

## Test plan
- **Basic write:** `CLK_DIV`=4, `start` with `data`=16'h1280 → SIOD sampled on SIOC rising edges gives 0x42, 0x12, 0x80 (ACK bits released) → `done` pulse 480 cycles after acceptance.
- **Conditions and release:** check that START is SIOD falling while SIOC=1, that STOP is SIOD rising while SIOC=1, that SIOD is never toggled while SIOC=1 elsewhere, and that `siod_oe`=0 on exactly the 3 ACK bits.
- **Busy and back-to-back:** `start` with `data`=16'h1100 while busy → ignored. Then `start` held high through the `done` cycle with `data`=16'h3a04 → second transaction begins immediately and a second `done` comes 480 cycles later.
- **Reset mid-transaction:** `reset` during phase 2 → next cycle `sioc`=1, `siod_out`=1, `siod_oe`=1, `ready`=1, no `done`. A following write of 16'h4010 completes normally.
- **NACK (macro defined):** `siod_in`=1 during the phase-2 ACK bit → `nack`=1 at `done`. Next write with `siod_in`=0 → `nack` clears at acceptance and stays 0. With the macro undefined → `nack` stays 0.
- **Sequencer loop:** connect `done` to the init sequencer's `continue` → 55 register writes issued in order, with the last `data` word equal to 16'h13e5.
